// File: rtl/sr_bank_pkg.sv
// Shared types and defaults for the SR bank write controller.
// Holds the controller state encoding and the default bank/counter widths.
package sr_bank_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

endpackage

// File: rtl/sr_excite.sv
// Per-bit SR excitation: turns (target, mask, shadow) into S/R levels.
// Combinational only; S and R are never both high for the same bit.
module sr_excite
  import sr_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter bit          FORCE = 1'b0
) (
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] shadow_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH-1:0] upd;

  always_comb begin
    // FORCE re-asserts the level on every masked bit; otherwise only bits that change are pulsed
    upd = FORCE ? mask_i : (mask_i & (target_i ^ shadow_i));
    s_o = upd & target_i;
    r_o = upd & ~target_i;
  end

endmodule

// File: rtl/sr_bank_writer.sv
// Write-side controller for a bank of SR flip-flops: clears the bank after reset,
// pulses S/R for one cycle per accepted request, then verifies q_fb against a shadow copy.
module sr_bank_writer
  import sr_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter bit          FORCE = 1'b0,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] shadow,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d, shadow_q, shadow_d;
  logic             done_q, done_d, err_q, err_d, init_q, init_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ex_s, ex_r;

  sr_excite #(.WIDTH(WIDTH), .FORCE(FORCE)) u_excite (
    .target_i (req_data),
    .mask_i   (req_mask),
    .shadow_i (shadow_q),
    .s_o      (ex_s),
    .r_o      (ex_r)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = '0;
    r_d      = '0;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    init_d   = init_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end

    case (state_q)
      ST_INIT: begin
        // Bank reset may be unwired, so clear it through R on every bit
        r_d      = '1;
        shadow_d = '0;
        init_d   = 1'b1;
        state_d  = ST_DRIVE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          s_d      = ex_s;
          r_d      = ex_r;
          shadow_d = (shadow_q & ~req_mask) | (req_data & req_mask);
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        done_d  = ~init_q;
        init_d  = 1'b0;
        state_d = ST_IDLE;
        // A mismatch beats a simultaneous clear so the event is never lost
        if (q_fb != shadow_q) begin
          err_d = 1'b1;
          if (err_clr)             cnt_d = CNT_ONE;
          else if (cnt_q != '1)    cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      s_q      <= '0;
      r_q      <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      r_q      <= r_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign shadow    = shadow_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_sr_bank_writer.sv
// Directed bench for sr_bank_writer: two instances (FORCE=0 and FORCE=1) share stimulus,
// each driving its own SR bank model; bit faults are injected on the FORCE=0 bank read-back.
module tb_sr_bank_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] req_mask = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] stuck0 = 8'h00;

  logic       req_ready, done, err;
  logic [7:0] s_out, r_out, q_fb, shadow, err_count;
  logic       f_req_ready, f_done, f_err;
  logic [7:0] f_s_out, f_r_out, f_q_fb, f_shadow, f_err_count;

  logic [7:0] bank_q   = 8'h3C;
  logic [7:0] f_bank_q = 8'hC3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_bank_writer #(.WIDTH(8), .FORCE(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .s_out(s_out), .r_out(r_out),
    .q_fb(q_fb), .shadow(shadow), .done(done), .err(err),
    .err_count(err_count), .err_clr(err_clr)
  );

  sr_bank_writer #(.WIDTH(8), .FORCE(1'b1), .CNT_W(8)) dut_f (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_data(req_data), .req_mask(req_mask), .s_out(f_s_out), .r_out(f_r_out),
    .q_fb(f_q_fb), .shadow(f_shadow), .done(f_done), .err(f_err),
    .err_count(f_err_count), .err_clr(err_clr)
  );

  // SR storage banks: set wins to 1, reset wins to 0, otherwise hold
  always @(posedge clk) begin
    bank_q   <= (bank_q & ~r_out) | s_out;
    f_bank_q <= (f_bank_q & ~f_r_out) | f_s_out;
  end
  assign q_fb   = bank_q & ~stuck0;
  assign f_q_fb = f_bank_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and return in the cycle where done should be visible
  task automatic do_req(input logic [7:0] d, input logic [7:0] m);
    req_valid = 1'b1;
    req_data  = d;
    req_mask  = m;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    chk("s_and_r", {24'h0, s_out & r_out}, 32'h0);
    chk("f_s_and_r", {24'h0, f_s_out & f_r_out}, 32'h0);
  end

  initial begin
    int acc;
    int dn;

    // Reset values
    tick();
    tick();
    chk("rst_s", s_out, 8'h00);
    chk("rst_r", r_out, 8'h00);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", err_count, 8'h00);
    rst = 1'b1;

    // INIT clear sequence
    tick();
    chk("init_r", r_out, 8'hFF);
    chk("init_s", s_out, 8'h00);
    chk("init_ready", req_ready, 1'b0);
    tick();
    chk("initchk_r", r_out, 8'h00);
    chk("initchk_done", done, 1'b0);
    tick();
    chk("init_idle_ready", req_ready, 1'b1);
    chk("init_shadow", shadow, 8'h00);
    chk("init_err", err, 1'b0);
    chk("init_nodone", done, 1'b0);
    chk("init_bank", q_fb, 8'h00);

    // Full write A5 from shadow 00
    req_valid = 1'b1; req_data = 8'hA5; req_mask = 8'hFF;
    tick();
    req_valid = 1'b0;
    chk("a5_s", s_out, 8'hA5);
    chk("a5_r", r_out, 8'h00);
    chk("a5_f_r", f_r_out, 8'h5A);
    chk("a5_drive_ready", req_ready, 1'b0);
    tick();
    chk("a5_chk_s", s_out, 8'h00);
    chk("a5_chk_done", done, 1'b0);
    tick();
    chk("a5_done", done, 1'b1);
    chk("a5_ready", req_ready, 1'b1);
    chk("a5_shadow", shadow, 8'hA5);
    chk("a5_err", err, 1'b0);
    tick();
    chk("a5_done_pulse", done, 1'b0);

    // Masked write 0F under F0
    req_valid = 1'b1; req_data = 8'h0F; req_mask = 8'hF0;
    tick();
    req_valid = 1'b0;
    chk("m_s", s_out, 8'h00);
    chk("m_r", r_out, 8'hA0);
    chk("m_f_s", f_s_out, 8'h00);
    chk("m_f_r", f_r_out, 8'hF0);
    tick();
    tick();
    chk("m_shadow", shadow, 8'h05);
    chk("m_done", done, 1'b1);
    chk("m_err", err, 1'b0);

    // Zero-mask request still completes with done
    do_req(8'hFF, 8'h00);
    chk("z_done", done, 1'b1);
    chk("z_shadow", shadow, 8'h05);

    // Bit 3 stuck at 0
    stuck0 = 8'h08;
    req_valid = 1'b1; req_data = 8'h08; req_mask = 8'hFF;
    tick();
    req_valid = 1'b0;
    chk("st_s", s_out, 8'h08);
    chk("st_r", r_out, 8'h05);
    tick();
    tick();
    chk("st_err", err, 1'b1);
    chk("st_cnt", err_count, 8'd1);
    chk("st_f_err", f_err, 1'b0);
    for (int i = 0; i < 299; i++) do_req(8'h08, 8'hFF);
    chk("sat_cnt", err_count, 8'd255);
    chk("sat_err", err, 1'b1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", err, 1'b0);
    chk("clr_cnt", err_count, 8'd0);

    do_req(8'h08, 8'hFF);
    chk("pre_cnt", err_count, 8'd1);
    // err_clr on the CHECK edge of a mismatching check
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clrwin_err", err, 1'b1);
    chk("clrwin_cnt", err_count, 8'd1);
    stuck0 = 8'h00;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr2_err", err, 1'b0);

    // Reset in the middle of DRIVE
    req_valid = 1'b1; req_data = 8'hF0; req_mask = 8'hFF;
    tick();
    req_valid = 1'b0;
    chk("rd_s", s_out, 8'hF0);
    chk("rd_r", r_out, 8'h08);
    #2 rst = 1'b0;
    #1;
    chk("rd_rst_s", s_out, 8'h00);
    chk("rd_rst_r", r_out, 8'h00);
    chk("rd_rst_shadow", shadow, 8'h00);
    chk("rd_rst_done", done, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("rd_init_r", r_out, 8'hFF);
    chk("rd_init_shadow", shadow, 8'h00);
    tick();
    chk("rd_chk_done", done, 1'b0);
    tick();
    chk("rd_idle_ready", req_ready, 1'b1);
    chk("rd_idle_done", done, 1'b0);
    chk("rd_idle_err", err, 1'b0);
    chk("rd_bank", q_fb, 8'h00);

    // Back-to-back requests with req_valid held
    acc = 0;
    dn  = 0;
    req_valid = 1'b1; req_data = 8'h55; req_mask = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc++;
      if (done) dn++;
      tick();
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 32'd4);
    chk("b2b_dones", dn, 32'd3);
    tick();
    tick();
    chk("b2b_shadow", shadow, 8'h55);
    chk("b2b_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
